flp_dec_digit_gen: RTL and testbench

Sequential decimal digit generator for the FLP-to-decimal path. It sits directly downstream of the fraction-split stage and consumes its 24-bit integer part Q and 24-bit left-aligned fractional part R. It emits the integer part as 8 packed BCD digits using iterative double-dabble, and the fractional part as FRAC_DIGITS packed BCD digits using repeated ×10. It uses a start/busy/done handshake.

---
 rtl/flp_dec_pkg.sv | 21 ++
 rtl/flp_dec_digit_gen_dabble_step.sv | 28 ++
 rtl/flp_dec_digit_gen.sv | 157 +++++++++++++++
 tb/tb_flp_dec_digit_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/flp_dec_pkg.sv
// flp_dec_pkg: shared widths and state encoding for the FLP-to-decimal digit generator.
// FLP_DEC_ROUND_EN adds the GUARD/ROUND states used for round-half-up on the last digit.
package flp_dec_pkg;

    localparam int INT_DIGITS = 8;
    localparam int Q_W        = 24;
    localparam int R_W        = 24;
    localparam int BCD_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INT   = 3'd1,
        S_FRAC  = 3'd2,
`ifdef FLP_DEC_ROUND_EN
        S_GUARD = 3'd3,
        S_ROUND = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/flp_dec_digit_gen_dabble_step.sv
// dabble_step: one double-dabble iteration. Adds 3 to every BCD nibble >= 5,
// then shifts the concatenation {bcd, bin} left by one bit.
module dabble_step
    import flp_dec_pkg::*;
(
    input  logic [INT_DIGITS*BCD_W-1:0] bcd,
    input  logic [Q_W-1:0]              bin,
    output logic [INT_DIGITS*BCD_W-1:0] bcd_next,
    output logic [Q_W-1:0]              bin_next
);

    logic [INT_DIGITS*BCD_W-1:0]     bcd_adj;
    logic [INT_DIGITS*BCD_W+Q_W-1:0] shifted;

    // Pre-correct each nibble so the following shift carries correctly into the next digit
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (bcd[i*BCD_W +: BCD_W] >= 4'd5)
                bcd_adj[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd3;
        end
    end

    assign shifted  = {bcd_adj, bin} << 1;
    assign bcd_next = shifted[INT_DIGITS*BCD_W+Q_W-1:Q_W];
    assign bin_next = shifted[Q_W-1:0];

endmodule

// File: rtl/flp_dec_digit_gen.sv
// flp_dec_digit_gen: converts a 24-bit integer part to 8 BCD digits (double-dabble)
// and a 24-bit fraction to FRAC_DIGITS BCD digits (repeated x10).
// Optional feature macro: FLP_DEC_ROUND_EN (round half-up using one guard digit).
//
// state | meaning
// IDLE  | waiting for start
// INT   | 24 double-dabble steps on the integer part
// FRAC  | one x10 fractional digit per cycle
// GUARD | extra x10 digit decides rounding (round build only)
// ROUND | BCD increment of the whole result (round build only)
// DONE  | results valid, done high for this cycle
module flp_dec_digit_gen
    import flp_dec_pkg::*;
#(
    parameter int FRAC_DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [Q_W-1:0]               q_in,
    input  logic [R_W-1:0]               r_in,
    output logic                         busy,
    output logic                         done,
    output logic [INT_DIGITS*BCD_W-1:0]  int_bcd,
    output logic [BCD_W*FRAC_DIGITS-1:0] frac_bcd
);

    localparam int IW = INT_DIGITS * BCD_W;
    localparam int FW = BCD_W * FRAC_DIGITS;
    localparam logic [4:0] INT_LAST  = 5'(Q_W - 1);
    localparam logic [4:0] FRAC_LAST = 5'(FRAC_DIGITS - 1);

    state_t          state;
    logic [Q_W-1:0]  bin;
    logic [IW-1:0]   bcd;
    logic [R_W-1:0]  frac;
    logic [FW-1:0]   frac_sr;
    logic [4:0]      cnt;

    logic [IW-1:0]    bcd_next;
    logic [Q_W-1:0]   bin_next;
    logic [R_W+3:0]   acc;
    logic [BCD_W-1:0] digit;
    logic [FW-1:0]    frac_shift;

    dabble_step u_dabble (
        .bcd      (bcd),
        .bin      (bin),
        .bcd_next (bcd_next),
        .bin_next (bin_next)
    );

    // frac*10 as shift-and-add; frac < 2^24 keeps the product below 10*2^24
    assign acc        = ({4'b0, frac} << 3) + ({4'b0, frac} << 1);
    assign digit      = acc[R_W+3:R_W];
    assign frac_shift = (frac_sr << BCD_W) | FW'(digit);

`ifdef FLP_DEC_ROUND_EN
    logic          round_up;
    logic [IW+FW-1:0] rnd;
    logic          carry;

    // Ripple a +1 through all fractional and integer BCD digits; carry out of the MSD is dropped
    always_comb begin
        rnd   = {bcd, frac_sr};
        carry = round_up;
        for (int i = 0; i < INT_DIGITS + FRAC_DIGITS; i++) begin
            if (carry) begin
                if (rnd[i*BCD_W +: BCD_W] == 4'd9) begin
                    rnd[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    rnd[i*BCD_W +: BCD_W] = rnd[i*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end
`endif

    // Sequencer with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bin      <= '0;
            bcd      <= '0;
            frac     <= '0;
            frac_sr  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            int_bcd  <= '0;
            frac_bcd <= '0;
`ifdef FLP_DEC_ROUND_EN
            round_up <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin   <= q_in;
                        bcd   <= '0;
                        frac  <= r_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_INT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_INT: begin
                    bcd <= bcd_next;
                    bin <= bin_next;
                    if (cnt == INT_LAST) begin
                        cnt   <= '0;
                        state <= S_FRAC;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_FRAC: begin
                    frac    <= acc[R_W-1:0];
                    frac_sr <= frac_shift;
                    if (cnt == FRAC_LAST) begin
                        cnt <= '0;
`ifdef FLP_DEC_ROUND_EN
                        state <= S_GUARD;
`else
                        int_bcd  <= bcd;
                        frac_bcd <= frac_shift;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
`endif
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
`ifdef FLP_DEC_ROUND_EN
                S_GUARD: begin
                    round_up <= (digit >= 4'd5);
                    state    <= S_ROUND;
                end
                S_ROUND: begin
                    int_bcd  <= rnd[IW+FW-1:FW];
                    frac_bcd <= rnd[FW-1:0];
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flp_dec_digit_gen.sv
// tb_flp_dec_digit_gen: directed vectors for the decimal digit generator (FRAC_DIGITS=4).
module tb_flp_dec_digit_gen;

`ifdef FLP_DEC_ROUND_EN
    localparam int LAT = 30;
`else
    localparam int LAT = 28;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] q_in = '0;
    logic [23:0] r_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] int_bcd;
    logic [15:0] frac_bcd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    flp_dec_digit_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q_in     (q_in),
        .r_in     (r_in),
        .busy     (busy),
        .done     (done),
        .int_bcd  (int_bcd),
        .frac_bcd (frac_bcd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation; pulse_edge>0 re-asserts start (with other data) so it is sampled at that edge
    task automatic run_op(input string tag, input logic [23:0] q, input logic [23:0] r,
                          input logic [31:0] exp_int, input logic [15:0] exp_frac,
                          input int pulse_edge, input bit idle_after);
        int lat;
        q_in  = q;
        r_in  = r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        q_in  = 24'hABCDEF;
        r_in  = 24'h123456;
        lat   = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                chk({tag, " busy@1"}, 64'(busy), 64'd1);
                chk({tag, " done@1"}, 64'(done), 64'd0);
            end
            if (pulse_edge > 0 && n == pulse_edge - 1) begin
                start = 1'b1;
                q_in  = 24'h000123;
                r_in  = 24'h111111;
            end
            if (n == pulse_edge) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
        chk({tag, " int"}, 64'(int_bcd), 64'(exp_int));
        chk({tag, " frac"}, 64'(frac_bcd), 64'(exp_frac));
        chk({tag, " busy@done"}, 64'(busy), 64'd0);
        if (idle_after) begin
            @(posedge clk); #1;
            chk({tag, " done 1 cycle"}, 64'(done), 64'd0);
            chk({tag, " int hold"}, 64'(int_bcd), 64'(exp_int));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset int", 64'(int_bcd), 64'd0);
        chk("reset frac", 64'(frac_bcd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("zero", 24'd0, 24'd0, 32'h00000000, 16'h0000, 0, 1'b1);
        run_op("max_half", 24'hFFFFFF, 24'h800000, 32'h16777215, 16'h5000, 0, 1'b0);
        run_op("b2b_quarter", 24'hFFFFFF, 24'h400000, 32'h16777215, 16'h2500, 0, 1'b1);
        run_op("third", 24'd0, 24'h555555, 32'h00000000, 16'h3333, 0, 1'b1);
`ifdef FLP_DEC_ROUND_EN
        run_op("nines", 24'd9, 24'hFFFFFF, 32'h00000010, 16'h0000, 0, 1'b1);
`else
        run_op("nines", 24'd9, 24'hFFFFFF, 32'h00000009, 16'h9999, 0, 1'b1);
`endif
        run_op("start_ignored", 24'd1234567, 24'h200000, 32'h01234567, 16'h1250, 10, 1'b1);
        run_op("tenth", 24'd100, 24'h19999A, 32'h00000100, 16'h1000, 0, 1'b1);

        // Abort an operation with reset at edge 15
        q_in  = 24'd777;
        r_in  = 24'h800000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst int", 64'(int_bcd), 64'd0);
        chk("rst frac", 64'(frac_bcd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 24'd42, 24'hC00000, 32'h00000042, 16'h7500, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
